// File: rtl/qq_pulse_sequencer.sv
// NMR echo-train sequencer: pre-delay, then N x (pulse, quench, acquisition).
// Optional build macro QQ_SEQ_DEADTIME_EN inserts a DEAD_CYC (>= 1) dead phase between pulse and quench.
module qq_pulse_sequencer #(
    parameter int CW = 16,
    parameter int NW = 8
`ifdef QQ_SEQ_DEADTIME_EN
    ,
    parameter int DEAD_CYC = 4
`endif
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] len_pre,
    input  logic [CW-1:0] len_pulse,
    input  logic [CW-1:0] len_qq,
    input  logic [CW-1:0] len_acq,
    input  logic [NW-1:0] n_echo,
    output logic          busy,
    output logic          pulse_out,
    output logic          qq_en,
    output logic          acq_en,
    output logic          done,
    output logic [2:0]    phase,
    output logic [NW-1:0] echo_idx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_QQ    = 3'd3;
    localparam logic [2:0] S_ACQ   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
`ifdef QQ_SEQ_DEADTIME_EN
    localparam logic [2:0] S_DEAD  = 3'd6;
`endif

    logic [2:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [NW-1:0] echo_nxt;
    logic [CW-1:0] lat_pulse, lat_qq, lat_acq;
    logic [NW-1:0] lat_n;
    logic          accept;
    logic          cnt_last;

    // A zero length still occupies one cycle, so the reload value saturates at 0.
    function automatic logic [CW-1:0] load_val(input logic [CW-1:0] len);
        return (len == '0) ? '0 : (len - CW'(1));
    endfunction

    assign accept   = (state == S_IDLE) && start && !abort;
    assign cnt_last = (cnt == '0);
    assign phase    = state;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        echo_nxt  = echo_idx;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_PRE;
                    cnt_nxt   = load_val(len_pre);
                    echo_nxt  = '0;
                end
            end
            S_PRE: begin
                if (cnt_last) begin
                    state_nxt = S_PULSE;
                    cnt_nxt   = load_val(lat_pulse);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_PULSE: begin
                if (cnt_last) begin
`ifdef QQ_SEQ_DEADTIME_EN
                    state_nxt = S_DEAD;
                    cnt_nxt   = CW'(DEAD_CYC - 1);
`else
                    state_nxt = S_QQ;
                    cnt_nxt   = load_val(lat_qq);
`endif
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
`ifdef QQ_SEQ_DEADTIME_EN
            S_DEAD: begin
                if (cnt_last) begin
                    state_nxt = S_QQ;
                    cnt_nxt   = load_val(lat_qq);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
`endif
            S_QQ: begin
                if (cnt_last) begin
                    state_nxt = S_ACQ;
                    cnt_nxt   = load_val(lat_acq);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_ACQ: begin
                // lat_n is never 0, so lat_n-1 cannot wrap.
                if (cnt_last) begin
                    if (echo_idx < (lat_n - NW'(1))) begin
                        state_nxt = S_PULSE;
                        cnt_nxt   = load_val(lat_pulse);
                        echo_nxt  = echo_idx + NW'(1);
                    end else begin
                        state_nxt = S_DONE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            echo_nxt  = echo_idx;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            echo_idx <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            echo_idx <= echo_nxt;
        end
    end

    // Configuration is captured only on an accepted start; the host may rewrite inputs mid-run.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            lat_pulse <= '0;
            lat_qq    <= '0;
            lat_acq   <= '0;
            lat_n     <= '0;
        end else if (accept) begin
            lat_pulse <= len_pulse;
            lat_qq    <= len_qq;
            lat_acq   <= len_acq;
            lat_n     <= (n_echo == '0) ? NW'(1) : n_echo;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            pulse_out <= 1'b0;
            qq_en     <= 1'b0;
            acq_en    <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy      <= (state_nxt != S_IDLE);
            pulse_out <= (state_nxt == S_PULSE);
            qq_en     <= (state_nxt == S_QQ);
            acq_en    <= (state_nxt == S_ACQ);
            done      <= (state_nxt == S_DONE);
        end
    end

endmodule
